// File: rtl/segre_mem_responder.sv
// Single-outstanding lane memory responder: accepts one read or write of a full
// lane, answers with a one-cycle ready strobe a fixed number of cycles later.
module segre_mem_responder #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned MEM_LANES   = 1024,
  parameter int unsigned LANE_SIZE   = 128,
  localparam int unsigned ADDR_SIZE        = 32,
  localparam int unsigned DCACHE_BYTE_SIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 mem_rd_i,
  input  logic                 mem_wr_i,
  input  logic [ADDR_SIZE-1:0] mem_addr_i,
  input  logic [LANE_SIZE-1:0] mem_data_i,
  output logic [LANE_SIZE-1:0] mem_rd_data_o,
  output logic                 mem_ready_o,
  output logic                 mem_busy_o
);

  localparam int unsigned IDX_W = $clog2(MEM_LANES);
  localparam logic [7:0]  CNT_LOAD = 8'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [7:0]           r_cnt;
  logic [7:0]           w_cnt_next;
  logic                 w_capture;
  logic                 w_rd_load;
  logic                 w_commit;

  logic [IDX_W-1:0]     r_idx;
  logic                 r_wr;
  logic [LANE_SIZE-1:0] r_data;
  logic [LANE_SIZE-1:0] r_rd_data;
  logic [LANE_SIZE-1:0] r_mem [MEM_LANES];

  logic [IDX_W-1:0]     w_in_idx;
  logic [IDX_W-1:0]     w_rd_idx;
  logic                 w_unused_addr;

  // Upper address bits beyond the lane count simply wrap onto the store.
  assign w_in_idx      = mem_addr_i[DCACHE_BYTE_SIZE +: IDX_W];
  assign w_unused_addr = ^{mem_addr_i[ADDR_SIZE-1:DCACHE_BYTE_SIZE+IDX_W],
                           mem_addr_i[DCACHE_BYTE_SIZE-1:0]};

  // With a one-cycle latency the read address comes straight off the port.
  assign w_rd_idx = (r_state == IDLE) ? w_in_idx : r_idx;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_rd_load    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_rd_i || mem_wr_i) begin
          w_capture = 1'b1;
          if (MEM_LATENCY == 1) begin
            w_state_next = RESP;
            w_rd_load    = !mem_wr_i;
          end else begin
            w_state_next = BUSY;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        w_cnt_next = r_cnt - 8'd1;
        if (r_cnt <= 8'd1) begin
          w_state_next = RESP;
          w_cnt_next   = 8'd0;
          w_rd_load    = !r_wr;
        end
      end
      RESP: begin
        w_state_next = IDLE;
        w_cnt_next   = 8'd0;
        w_commit     = r_wr;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Write wins over read when both strobes arrive together.
  always_ff @(posedge clk_i) begin
    if (rsn_i && w_capture) begin
      r_idx  <= w_in_idx;
      r_wr   <= mem_wr_i;
      r_data <= mem_data_i;
    end
  end

  // Backing store is never cleared; an aborted request never reaches RESP.
  always_ff @(posedge clk_i) begin
    if (rsn_i && w_commit) begin
      r_mem[r_idx] <= r_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      r_rd_data <= '0;
    end else if (w_rd_load) begin
      r_rd_data <= r_mem[w_rd_idx];
    end
  end

  assign mem_rd_data_o = r_rd_data;
  assign mem_ready_o   = (r_state == RESP);
  assign mem_busy_o    = (r_state != IDLE);

endmodule

// File: tb/tb_segre_mem_responder.sv
// Scoreboard bench: a latency-4 instance and a latency-1 instance share stimulus
// through a select bit; responses are checked for data and timing as they appear.
module tb_segre_mem_responder;

  logic         clk = 1'b0;
  logic         rsn = 1'b0;
  logic         t_rd = 1'b0, t_wr = 1'b0, t_sel = 1'b0;
  logic [31:0]  t_addr = '0;
  logic [127:0] t_data = '0;
  int           cyc = 0;
  int           n_checks = 0, n_pass = 0;

  logic         rd0, wr0, rd1, wr1;
  logic [127:0] rdata0, rdata1;
  logic         ready0, busy0, ready1, busy1;

  assign rd0 = t_rd & ~t_sel;
  assign wr0 = t_wr & ~t_sel;
  assign rd1 = t_rd & t_sel;
  assign wr1 = t_wr & t_sel;

  segre_mem_responder #(.MEM_LATENCY(4), .MEM_LANES(1024), .LANE_SIZE(128)) dut (
    .clk_i(clk), .rsn_i(rsn), .mem_rd_i(rd0), .mem_wr_i(wr0),
    .mem_addr_i(t_addr), .mem_data_i(t_data), .mem_rd_data_o(rdata0),
    .mem_ready_o(ready0), .mem_busy_o(busy0));

  segre_mem_responder #(.MEM_LATENCY(1), .MEM_LANES(16), .LANE_SIZE(128)) dut1 (
    .clk_i(clk), .rsn_i(rsn), .mem_rd_i(rd1), .mem_wr_i(wr1),
    .mem_addr_i(t_addr), .mem_data_i(t_data), .mem_rd_data_o(rdata1),
    .mem_ready_o(ready1), .mem_busy_o(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t         q0[$], q1[$];
  logic [127:0] m0 [1024];
  logic [127:0] m1 [16];
  logic [127:0] last_rd0 = '0, last_rd1 = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Drive a request at a falling edge; it is sampled at the next rising edge.
  task automatic issue(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [127:0] data, input bit push);
    exp_t e;
    int   idx;
    t_sel = sel; t_rd = rd; t_wr = wr; t_addr = addr; t_data = data;
    e.acc = cyc + 1;
    if (push) begin
      if (!sel) begin
        idx = int'(addr[13:4]);
        if (wr) begin m0[idx] = data; e.data = last_rd0; end
        else begin e.data = m0[idx]; last_rd0 = e.data; end
        q0.push_back(e);
      end else begin
        idx = int'(addr[7:4]);
        if (wr) begin m1[idx] = data; e.data = last_rd1; end
        else begin e.data = m1[idx]; last_rd1 = e.data; end
        q1.push_back(e);
      end
      $display("req sel=%0d rd=%0d wr=%0d addr=%h data=%h acc=%0d", sel, rd, wr, addr, data, e.acc);
    end
    @(posedge clk);
    @(negedge clk);
    t_rd = 1'b0; t_wr = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    for (int i = 0; i < 20 && (sel ? busy1 : busy0); i++) @(negedge clk);
    chk("idle_timeout", 128'(sel ? busy1 : busy0), 128'(0));
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (ready0) begin
      if (q0.size() == 0) chk("unexp_ready0", 128'(1), 128'(0));
      else begin
        e = q0.pop_front();
        $display("rsp0 cyc=%0d data=%h", cyc, rdata0);
        chk("rdata0", rdata0, e.data);
        chk("lat0", 128'(cyc), 128'(e.acc + 3));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (ready1) begin
      if (q1.size() == 0) chk("unexp_ready1", 128'(1), 128'(0));
      else begin
        e = q1.pop_front();
        $display("rsp1 cyc=%0d data=%h", cyc, rdata1);
        chk("rdata1", rdata1, e.data);
        chk("lat1", 128'(cyc), 128'(e.acc));
      end
    end
  end

  initial begin
    logic [31:0] lanes [5];
    lanes[0] = 32'h0; lanes[1] = 32'h40; lanes[2] = 32'h80;
    lanes[3] = 32'h100; lanes[4] = 32'h200;

    // Request held through reset must be ignored until rsn rises.
    @(negedge clk);
    t_wr = 1'b1; t_addr = 32'h200; t_data = {4{32'h5A5A_0200}};
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 128'(ready0), 128'(0));
      chk("rst_busy", 128'(busy0), 128'(0));
      chk("rst_rdata", rdata0, 128'(0));
    end
    rsn = 1'b1;
    issue(0, 0, 1, 32'h200, {4{32'h5A5A_0200}}, 1);
    wait_idle(0);

    issue(0, 0, 1, 32'h40, 128'h0123456789ABCDEF0123456789ABCDEF, 1);
    wait_idle(0);
    issue(0, 1, 0, 32'h4C, '0, 1);
    wait_idle(0);

    issue(0, 1, 1, 32'h100, {16{8'hAA}}, 1);
    wait_idle(0);
    chk("both_rdata_kept", rdata0, last_rd0);
    issue(0, 1, 0, 32'h100, '0, 1);
    wait_idle(0);

    issue(0, 0, 1, 32'h4000, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1);
    wait_idle(0);
    issue(0, 1, 0, 32'h0, '0, 1);
    wait_idle(0);

    // Second read pulsed mid-flight must vanish.
    issue(0, 1, 0, 32'h40, '0, 1);
    t_sel = 1'b0; t_rd = 1'b1; t_addr = 32'h100;
    @(negedge clk);
    chk("drop_busy", 128'(busy0), 128'(1));
    t_rd = 1'b0;
    for (int i = 0; i < 10 && !ready0; i++) begin
      chk("drop_busy_hold", 128'(busy0), 128'(1));
      @(negedge clk);
    end
    chk("drop_busy_resp", 128'(busy0), 128'(1));
    @(negedge clk);
    chk("drop_busy_after", 128'(busy0), 128'(0));
    repeat (8) @(negedge clk);

    // Abort an in-flight write with reset on its second BUSY cycle.
    issue(0, 0, 1, 32'h80, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1);
    wait_idle(0);
    issue(0, 0, 1, 32'h80, {4{32'hBAD0_BAD0}}, 0);
    @(negedge clk);
    rsn = 1'b0;
    @(negedge clk);
    chk("abort_ready", 128'(ready0), 128'(0));
    chk("abort_busy", 128'(busy0), 128'(0));
    chk("abort_rdata", rdata0, 128'(0));
    rsn = 1'b1;
    last_rd0 = '0; last_rd1 = '0;
    repeat (8) @(negedge clk);
    issue(0, 1, 0, 32'h80, '0, 1);
    wait_idle(0);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      a = lanes[$urandom_range(0, 4)] | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) issue(0, 1, 0, a, '0, 1);
      else issue(0, 0, 1, a, {$urandom, $urandom, $urandom, $urandom}, 1);
      wait_idle(0);
    end

    // Latency-1 instance: ready and busy for one cycle only, lanes wrap at 16.
    issue(1, 0, 1, 32'h30, 128'hCAFE_F00D_0000_0000_0000_0000_1234_5678, 1);
    chk("l1_wr_busy", 128'(busy1), 128'(1));
    @(negedge clk);
    chk("l1_wr_idle", 128'(busy1), 128'(0));
    issue(1, 1, 0, 32'h130, '0, 1);
    chk("l1_rd_ready", 128'(ready1), 128'(1));
    chk("l1_rd_busy", 128'(busy1), 128'(1));
    @(negedge clk);
    chk("l1_rd_idle", 128'(busy1), 128'(0));
    chk("l1_rd_noready", 128'(ready1), 128'(0));

    repeat (6) @(negedge clk);
    chk("q0_empty", 128'(q0.size()), 128'(0));
    chk("q1_empty", 128'(q1.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/segre_mem_responder.md
SEGRE_MEM_RESPONDER -- requirements
Module: segre_mem_responder

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4: cycles from request acceptance to response; legal range 1..255.
REQ-002 SHALL have parameter MEM_LANES, default 1024: number of 128-bit lanes in backing store; power of two.
REQ-003 SHALL have parameter LANE_SIZE, default DCACHE_LANE_SIZE (128): lane width in bits.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rsn_i, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port mem_rd_i, input, 1: lane read request from MMU.
REQ-007 SHALL have port mem_wr_i, input, 1: lane write request from MMU.
REQ-008 SHALL have port mem_addr_i, input, ADDR_SIZE (32): byte address of the request.
REQ-009 SHALL have port mem_data_i, input, LANE_SIZE: write data.
REQ-010 SHALL have port mem_rd_data_o, output, LANE_SIZE: read response data.
REQ-011 SHALL have port mem_ready_o, output, 1: one-cycle response strobe, read data valid or write committed.
REQ-012 SHALL have port mem_busy_o, output, 1: request in flight; new requests ignored.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 IDLE: mem_rd_i or mem_wr_i high at a rising edge -> capture addr, data and op type, load counter with MEM_LATENCY-1, go BUSY; if MEM_LATENCY=1, go RESP directly.
REQ-015 BUSY: decrement counter each cycle; at counter 0 go RESP.
REQ-016 RESP: mem_ready_o=1 for exactly that cycle; next state IDLE.
REQ-017 Latency: request sampled at edge N -> mem_ready_o high during the cycle after edge N+MEM_LATENCY-1, i.e. MEM_LATENCY cycles after acceptance.
REQ-018 mem_busy_o SHALL be 1 in BUSY and RESP, 0 in IDLE.
REQ-019 Requests seen in BUSY or RESP SHALL be ignored and dropped; requester holds or re-issues after mem_ready_o.
REQ-020 Request in the IDLE cycle right after RESP SHALL be accepted (back-to-back permitted, one idle cycle between responses minimum).
REQ-021 mem_rd_i and mem_wr_i both high at acceptance: write SHALL take priority; read dropped, no read data update.
REQ-022 Lane index = mem_addr_i[ADDR_SIZE-1:DCACHE_BYTE_SIZE] modulo MEM_LANES; byte offset bits [3:0] ignored; out-of-range addresses wrap.
REQ-023 Write: captured data SHALL be written to the lane at the RESP edge; memory unchanged before RESP.
REQ-024 Read: mem_rd_data_o SHALL present the lane contents in the RESP cycle, including any write committed by an earlier completed request.
REQ-025 mem_rd_data_o SHALL hold its last read value until the next read response; write responses do not change it.
REQ-026 Captured request fields SHALL be stable from acceptance to RESP regardless of input changes.

Reset
REQ-027 rsn_i=0 at an edge SHALL force state IDLE, counter 0, mem_ready_o=0, mem_busy_o=0, mem_rd_data_o=0.
REQ-028 Reset during BUSY or RESP SHALL abort the request: no write committed, no mem_ready_o pulse.
REQ-029 Backing store contents SHALL NOT be altered by reset.
REQ-030 Request inputs high while rsn_i=0 SHALL be ignored; first acceptance on the first edge with rsn_i=1.

Verification
REQ-031 Write 0x0123...CDEF to addr 0x40, then read 0x4C -> write ready after 4 cycles, read ready 4 cycles after acceptance, data 0x0123...CDEF.
REQ-032 MEM_LATENCY=1: read at edge N -> mem_ready_o high cycle after edge N, busy high that cycle only.
REQ-033 Read accepted, second read pulsed during BUSY -> single mem_ready_o, second request dropped, busy 1 throughout.
REQ-034 rd and wr both high, addr 0x100, data 0xAA..AA -> write committed, mem_rd_data_o unchanged; subsequent read returns 0xAA..AA.
REQ-035 Write to 0x80, rsn_i=0 on 2nd BUSY cycle -> no mem_ready_o, all outputs 0; read 0x80 returns prior contents.
REQ-036 Address 0x4000 with MEM_LANES=1024 -> aliases lane 0; write there, read 0x0 returns the same data.
